// File: rtl/herring_uart.sv
// herring_uart: 8N1 serial port on the 6502 bus with 16-entry TX and RX FIFOs and a level IRQ.
// Latency: bus accesses commit 3 clk_src after the phase-2 fall; txd falls 2 cycles after a DATA write commit.
// Backpressure: a DATA write into a full TX FIFO is dropped; an RX byte into a full RX FIFO is dropped and sets overrun.
//
// Ports: clk_src/reset (sync, active high); CPU bus cpu_clk_out, cs_n, rw, reg_sel, data_in,
//        data_out, data_oe; irq_n (registered, active low); serial txd (idles high), rxd (async).

// Generic synchronous FIFO. Full-and-pop in the same cycle accepts the push.
module herring_uart_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic         clk_src,
   input  logic         reset,
   input  logic         push_vld,
   input  logic [W-1:0] push_dat,
   input  logic         pop_vld,
   output logic [W-1:0] head_dat,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         push_ok;
   logic         pop_ok;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok   = pop_vld & ~empty;
   assign push_ok  = push_vld & (~full | pop_ok);
   assign head_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_src) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk_src) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
   end
endmodule

module herring_uart #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic       clk_src,
   input  logic       reset,
   input  logic       cpu_clk_out,
   input  logic       cs_n,
   input  logic       rw,
   input  logic [1:0] reg_sel,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic       irq_n,
   output logic       txd,
   input  logic       rxd
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE  = 1;

   typedef struct packed {
      logic       cs_n;
      logic       rw;
      logic [1:0] reg_sel;
      logic [7:0] dat;
   } bus_t;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // ---------------- bus capture ----------------
   logic p2_s1, p2_s2, p2_d;
   bus_t bus_lat;
   logic commit_vld, wr_data, rd_data, wr_stat, wr_ctrl;

   always_ff @(posedge clk_src) begin
      if (reset) begin
         p2_s1   <= 1'b0;
         p2_s2   <= 1'b0;
         p2_d    <= 1'b0;
         bus_lat <= '{cs_n: 1'b1, rw: 1'b1, reg_sel: 2'b00, dat: 8'h00};
      end else begin
         p2_s1 <= cpu_clk_out;
         p2_s2 <= p2_s1;
         p2_d  <= p2_s2;
         // Keep refreshing while phase-2 is high; the last copy is what commits.
         if (p2_s2) bus_lat <= '{cs_n: cs_n, rw: rw, reg_sel: reg_sel, dat: data_in};
      end
   end

   assign commit_vld = p2_d & ~p2_s2 & ~bus_lat.cs_n;
   assign wr_data    = commit_vld & ~bus_lat.rw & (bus_lat.reg_sel == 2'd0);
   assign rd_data    = commit_vld &  bus_lat.rw & (bus_lat.reg_sel == 2'd0);
   assign wr_stat    = commit_vld & ~bus_lat.rw & (bus_lat.reg_sel == 2'd1);
   assign wr_ctrl    = commit_vld & ~bus_lat.rw & (bus_lat.reg_sel == 2'd2);

   // ---------------- FIFOs ----------------
   logic [7:0] tx_head, rx_head, rx_shift;
   logic       tx_full, tx_empty, rx_full, rx_empty;
   logic       tx_pop, rx_push_vld;
   tx_state_t  tx_state;
   rx_state_t  rx_state;

   herring_uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk_src (clk_src),
      .reset   (reset),
      .push_vld(wr_data),
      .push_dat(bus_lat.dat),
      .pop_vld (tx_pop),
      .head_dat(tx_head),
      .full    (tx_full),
      .empty   (tx_empty)
   );

   herring_uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk_src (clk_src),
      .reset   (reset),
      .push_vld(rx_push_vld),
      .push_dat(rx_shift),
      .pop_vld (rd_data),
      .head_dat(rx_head),
      .full    (rx_full),
      .empty   (rx_empty)
   );

   // ---------------- transmitter ----------------
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_shift;
   logic          tx_idle;

   assign tx_pop  = (tx_state == TX_IDLE) & ~tx_empty;
   assign tx_idle = tx_empty & (tx_state == TX_IDLE);

   // txd is a registered copy of the current state's line level, so it trails
   // the state by one cycle; every bit still lasts exactly CLKS_PER_BIT.
   always_ff @(posedge clk_src) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         txd      <= 1'b1;
      end else begin
         txd <= (tx_state == TX_START) ? 1'b0 :
                (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
         case (tx_state)
            TX_IDLE: begin
               if (!tx_empty) begin
                  tx_shift <= tx_head;
                  tx_cnt   <= '0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt == BIT_END) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  tx_state <= TX_DATA;
               end else tx_cnt <= tx_cnt + CNT_ONE;
            end
            TX_DATA: begin
               if (tx_cnt == BIT_END) begin
                  tx_cnt   <= '0;
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  if (tx_bit == 3'd7) tx_state <= TX_STOP;
                  else                tx_bit   <= tx_bit + 3'd1;
               end else tx_cnt <= tx_cnt + CNT_ONE;
            end
            TX_STOP: begin
               if (tx_cnt == BIT_END) begin
                  tx_cnt   <= '0;
                  tx_state <= TX_IDLE;
               end else tx_cnt <= tx_cnt + CNT_ONE;
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // ---------------- receiver ----------------
   logic          rx_s1, rx_s2;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic          fe_evt, ov_evt;

   assign rx_push_vld = (rx_state == RX_STOP) & (rx_cnt == BIT_END);
   assign fe_evt      = rx_push_vld & ~rx_s2;
   // A pop committing in the same cycle frees a slot, so that push is not an overrun.
   assign ov_evt      = rx_push_vld & rx_full & ~rd_data;

   always_ff @(posedge clk_src) begin
      if (reset) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_s1 <= rxd;
         rx_s2 <= rx_s1;
         case (rx_state)
            RX_IDLE: begin
               if (!rx_s2) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF_END) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  // Line back high at mid start bit means it was a glitch.
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
               end else rx_cnt <= rx_cnt + CNT_ONE;
            end
            RX_DATA: begin
               if (rx_cnt == BIT_END) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
                  else                rx_bit   <= rx_bit + 3'd1;
               end else rx_cnt <= rx_cnt + CNT_ONE;
            end
            RX_STOP: begin
               if (rx_cnt == BIT_END) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_IDLE;
               end else rx_cnt <= rx_cnt + CNT_ONE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // ---------------- control, flags, interrupt ----------------
   logic [1:0] ctrl;
   logic       overrun, framing_err;
   logic [7:0] status;

   always_ff @(posedge clk_src) begin
      if (reset) begin
         ctrl        <= 2'b00;
         overrun     <= 1'b0;
         framing_err <= 1'b0;
         irq_n       <= 1'b1;
      end else begin
         if (wr_ctrl) ctrl <= bus_lat.dat[1:0];
         // A new error event in the same cycle as a clear wins.
         if (wr_stat) begin
            overrun     <= 1'b0;
            framing_err <= 1'b0;
         end
         if (ov_evt) overrun     <= 1'b1;
         if (fe_evt) framing_err <= 1'b1;
         irq_n <= ~((ctrl[0] & ~rx_empty) | (ctrl[1] & tx_idle));
      end
   end

   assign status  = {~irq_n, 2'b00, tx_idle, framing_err, overrun, ~tx_full, ~rx_empty};
   assign data_oe = ~cs_n & rw & cpu_clk_out;

   always_comb begin
      data_out = 8'h00;
      if (!cs_n && rw) begin
         case (reg_sel)
            2'd0:    data_out = rx_empty ? 8'h00 : rx_head;
            2'd1:    data_out = status;
            2'd2:    data_out = {6'b000000, ctrl};
            default: data_out = 8'h00;
         endcase
      end
   end
endmodule

// File: doc/herring_uart.md
# herring_uart

Bus-attached 8N1 serial port for the Herring 6502 board, mapped into the ACIA 1 window at 0x8000 and selected by the address decoder's ACIA chip-select output. It runs entirely on the 50 MHz board oscillator. It samples the 6502 bus against a synchronized copy of the CPU phase-2 clock, and buffers traffic in 16-byte TX and RX FIFOs. Interrupts are level, active-low, and go to the CPU IRQB line.

## Interface
- CLKS_PER_BIT, 434, clk_src cycles per serial bit (50 MHz / 115200); must be ≥ 16
- FIFO_DEPTH, 16, entries per FIFO; power of two, ≥ 2
- clk_src  in  1  50 MHz board oscillator; the block's only clock
- reset  in  1  synchronous, active-high reset
- cpu_clk_out  in  1  6502 phase-2 clock, asynchronous to clk_src
- cs_n  in  1  chip select from the decoder, active low
- rw  in  1  6502 RWB: 1 = read, 0 = write
- reg_sel  in  2  register select, CPU A1:A0
- data_in  in  8  CPU data bus, write direction
- data_out  out  8  CPU data bus, read direction
- data_oe  out  1  bus drive enable for the external transceiver
- irq_n  out  1  interrupt request, active low
- txd  out  1  serial transmit, idles high
- rxd  in  1  serial receive, asynchronous

## Operation
- Registers:
  - reg 0 DATA: a write pushes data_in to the TX FIFO; a read returns the RX FIFO head and pops it.
  - reg 1 STATUS (read): bit0 rx_avail, bit1 tx_not_full, bit2 overrun, bit3 framing_err, bit4 tx_idle (TX FIFO empty and shifter in IDLE), bit7 irq, other bits 0. Any write to reg 1 clears bits 2 and 3.
  - reg 2 CTRL (read/write): bit0 rx_irq_en, bit1 tx_irq_en, other bits read 0.
  - reg 3: reads 0x00; writes are ignored.
- Bus capture:
  - cpu_clk_out passes through a 2-flop synchronizer.
  - While the synchronized phase-2 is 1, cs_n, rw, reg_sel and data_in are latched every clk_src cycle.
  - On the synchronized falling edge, a pending access is committed (write, pop, or flag clear) using the latched values, exactly once per phase-2 cycle.
- data_out is combinational from reg_sel and current state, so it is stable across phase-2 high. It is 0x00 unless cs_n=0 and rw=1.
- data_oe = ~cs_n & rw & cpu_clk_out, combinational on the raw phase-2 clock.
- Reading DATA with the RX FIFO empty returns 0x00 and does not pop.
- Writing DATA with the TX FIFO full discards the byte; no flag is set.
- TX states:
  - IDLE: if the FIFO is non-empty, pop the head into the shifter and go to START.
  - START: txd=0.
  - DATA: 8 bits, LSB first.
  - STOP: txd=1, then back to IDLE.
  - Each of START, DATA-bit and STOP lasts CLKS_PER_BIT cycles.
- RX:
  - rxd passes through a 2-flop synchronizer that resets to 1.
  - IDLE: on synchronized rxd=0, go to START.
  - START: after CLKS_PER_BIT/2 cycles, resample. If it is 1 (glitch), return to IDLE; otherwise go to DATA.
  - DATA: 8 samples spaced CLKS_PER_BIT apart, LSB first.
  - STOP: one sample CLKS_PER_BIT later. If it is 0, set framing_err (sticky). The byte is pushed either way. Then return to IDLE in the same cycle.
- RX push when the FIFO is full: the byte is dropped and overrun is set (sticky). If a CPU pop commits in the same cycle, the push is accepted and overrun is not set.
- FIFO push and pop in the same cycle: both occur and the count is unchanged.
- irq_n is registered: irq_n = ~((rx_irq_en & rx_avail) | (tx_irq_en & tx_idle)).

## Timing
- Reset values:
  - txd=1, irq_n=1, data_oe follows its equation (0 while cs_n=1).
  - Both FIFOs empty, CTRL=0x00, overrun=0, framing_err=0.
  - Both FSMs in IDLE, synchronizers at 1 (rxd) and 0 (phase-2).
- Reset mid-frame aborts TX immediately: txd=1 on the cycle after reset is sampled. Any RX byte in progress is discarded.
- Write commit occurs 3 clk_src cycles after the falling edge of cpu_clk_out (2-flop sync plus edge detect). The same applies to pops and flag clears.
- TX latency, FIFO empty and shifter idle: txd falls 2 cycles after write commit (IDLE pop, then START).
- Back-to-back TX bytes: stop bit, then one IDLE cycle, then the next start bit. Frame length is 10×CLKS_PER_BIT + 1 cycles.
- RX push occurs at the stop-bit sample, 9.5×CLKS_PER_BIT (±1) cycles after the synchronized falling edge of the start bit.
- irq_n updates 1 cycle after its inputs change.

## Test plan
- Reset, then read STATUS → 0x12 (tx_not_full, tx_idle); txd=1; irq_n=1.
- Write 0x55 to DATA → txd carries: start bit (0), bits 1,0,1,0,1,0,1,0, stop bit (1); each bit is 434±0 cycles; the falling edge is 5 cycles after the cpu_clk_out fall (3 cycles to commit, plus 2).
- Drive rxd with 0xA3 at 115200 baud → STATUS bit0=1; reading DATA returns 0xA3; the next STATUS read has bit0=0.
- Receive 17 bytes without reading → STATUS bit2=1; reading 16 times returns the first 16 bytes in order; a 17th read returns 0x00; writing reg 1 clears bit2.
- Drive a frame with stop bit 0 → framing_err=1 and the byte is still readable. Drive a 1-µs low glitch → nothing is received and no flags change.
- CTRL=0x01 and a byte is received → irq_n=0 one cycle after the push, returns to 1 after the DATA read. Assert reset mid-TX → txd=1 on the next cycle and the FIFOs are empty.
